// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the configuration frame loader.
package cfg_pkg;

    localparam logic [7:0] HDR_DEFAULT       = 8'hAA;
    localparam int         FRAME_LEN_DEFAULT = 113;
    localparam int         TIMEOUT_DEFAULT   = 50000;

    // Command byte that tells the downstream logic to start with the new setup.
    localparam logic [7:0] CMD_START = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAYLOAD = 3'd1,
        CHECK   = 3'd2,
        COMMIT  = 3'd3,
        ERR     = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/cfg_timeout.sv
// Inter-byte idle counter: clears on every received byte, counts only while
// enabled, and flags expiry once it has seen TIMEOUT_CYC idle clocks.
module cfg_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk_CFG,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_reg;

    assign expired = (cnt_reg == CW'(TIMEOUT_CYC));

    // Idle-clock counter; saturates at the limit so expiry stays asserted.
    always_ff @(posedge clk_CFG or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || !count_en) begin
            cnt_reg <= '0;
        end else if (!expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_loader.sv
// Receives a header-framed configuration stream from a UART and loads it into
// the channel RAM. Payload is written top-down; the final payload byte is a
// command that is only written to address 0 once the XOR checksum matches.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    parameter int         FRAME_LEN   = FRAME_LEN_DEFAULT,
    parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic       clk_CFG,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] ram_in,
    output logic [7:0] ram_w_addr,
    output logic       ram_write_n,
    output logic       ram_read,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err
);

    cfg_state_t state_reg, state_next;

    logic [7:0] addr_reg, addr_next;
    logic [7:0] csum_reg, csum_next;
    logic [7:0] cmd_reg, cmd_next;
    logic [7:0] ram_in_reg, ram_in_next;
    logic [7:0] ram_w_addr_reg, ram_w_addr_next;
    logic       ram_write_n_reg, ram_write_n_next;
    logic       ram_read_reg, ram_read_next;
    logic       timeout_expired;

    assign ram_in      = ram_in_reg;
    assign ram_w_addr  = ram_w_addr_reg;
    assign ram_write_n = ram_write_n_reg;
    assign ram_read    = ram_read_reg;

    cfg_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_CFG (clk_CFG),
        .rst_n   (rst_n),
        .clear   (rx_valid),
        .count_en((state_reg == PAYLOAD) || (state_reg == CHECK)),
        .expired (timeout_expired)
    );

    // State register.
    always_ff @(posedge clk_CFG or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a byte arriving in the expiry cycle takes priority.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rx_valid && (rx_data == HDR)) begin
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (addr_reg == 8'd0) begin
                        state_next = CHECK;
                    end
                end else if (timeout_expired) begin
                    state_next = ERR;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    state_next = (rx_data == csum_reg) ? COMMIT : ERR;
                end else if (timeout_expired) begin
                    state_next = ERR;
                end
            end
            COMMIT:  state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy      = 1'b0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        case (state_reg)
            PAYLOAD, CHECK: busy = 1'b1;
            COMMIT: begin
                busy     = 1'b1;
                frame_ok = 1'b1;
            end
            ERR:     frame_err = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values; RAM port values are registered so each accepted
    // byte yields one write strobe on the following cycle. The address-0
    // commit write is launched with the matching checksum byte so it lands
    // in the COMMIT cycle together with frame_ok and ram_read.
    always_comb begin
        addr_next        = addr_reg;
        csum_next        = csum_reg;
        cmd_next         = cmd_reg;
        ram_in_next      = ram_in_reg;
        ram_w_addr_next  = ram_w_addr_reg;
        ram_write_n_next = 1'b1;
        ram_read_next    = ram_read_reg;
        case (state_reg)
            IDLE: begin
                if (rx_valid && (rx_data == HDR)) begin
                    addr_next     = 8'(FRAME_LEN - 1);
                    csum_next     = 8'd0;
                    ram_read_next = 1'b0;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    csum_next = csum_reg ^ rx_data;
                    if (addr_reg != 8'd0) begin
                        ram_in_next      = rx_data;
                        ram_w_addr_next  = addr_reg;
                        ram_write_n_next = 1'b0;
                        addr_next        = addr_reg - 8'd1;
                    end else begin
                        cmd_next = rx_data;
                    end
                end
            end
            CHECK: begin
                if (rx_valid && (rx_data == csum_reg)) begin
                    ram_in_next      = cmd_reg;
                    ram_w_addr_next  = 8'd0;
                    ram_write_n_next = 1'b0;
                    ram_read_next    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_CFG or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg        <= 8'd0;
            csum_reg        <= 8'd0;
            cmd_reg         <= 8'd0;
            ram_in_reg      <= 8'd0;
            ram_w_addr_reg  <= 8'd0;
            ram_write_n_reg <= 1'b1;
            ram_read_reg    <= 1'b0;
        end else begin
            addr_reg        <= addr_next;
            csum_reg        <= csum_next;
            cmd_reg         <= cmd_next;
            ram_in_reg      <= ram_in_next;
            ram_w_addr_reg  <= ram_w_addr_next;
            ram_write_n_reg <= ram_write_n_next;
            ram_read_reg    <= ram_read_next;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed testbench for cfg_loader: good, bad-checksum, timeout, reset and
// back-to-back frames, with a write monitor collecting the RAM traffic.
module tb_cfg_loader;
    import cfg_pkg::*;

    localparam int T  = 200;
    localparam int FL = 113;

    logic       clk_CFG  = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'd0;
    logic [7:0] ram_in;
    logic [7:0] ram_w_addr;
    logic       ram_write_n;
    logic       ram_read;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wq [$];
    int ok_cnt  = 0;
    int err_cnt = 0;

    cfg_loader #(
        .HDR        (8'hAA),
        .FRAME_LEN  (FL),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk_CFG    (clk_CFG),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .ram_in     (ram_in),
        .ram_w_addr (ram_w_addr),
        .ram_write_n(ram_write_n),
        .ram_read   (ram_read),
        .busy       (busy),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    always #5 clk_CFG = ~clk_CFG;

    // Monitor: capture every low write-strobe cycle and status pulses.
    always @(negedge clk_CFG) begin
        if (!ram_write_n) begin
            mem[ram_w_addr] = ram_in;
            wq.push_back(ram_w_addr);
        end
        if (frame_ok)  ok_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        if (i < 0 || i >= wq.size()) return 32'hDEAD_BEEF;
        return {24'd0, wq[i]};
    endfunction

    function automatic int addr0_writes();
        int n = 0;
        foreach (wq[i]) if (wq[i] == 8'd0) n++;
        return n;
    endfunction

    function automatic logic [7:0] pay(input int a, input logic [7:0] seed);
        return 8'(a) ^ seed;
    endfunction

    function automatic logic [7:0] frame_csum(input logic [7:0] seed, input logic [7:0] cmd);
        logic [7:0] x = cmd;
        for (int a = 1; a < FL; a++) x = x ^ pay(a, seed);
        return x;
    endfunction

    task automatic clr();
        wq.delete();
        ok_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_CFG);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk_CFG);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seed, input logic [7:0] cmd,
                              input logic [7:0] flip, input bit b2b);
        logic [7:0] bytes [$];
        bytes.push_back(8'hAA);
        for (int a = FL - 1; a >= 1; a--) bytes.push_back(pay(a, seed));
        bytes.push_back(cmd);
        bytes.push_back(frame_csum(seed, cmd) ^ flip);
        if (b2b) begin
            foreach (bytes[i]) begin
                @(negedge clk_CFG);
                rx_data  = bytes[i];
                rx_valid = 1'b1;
            end
            @(negedge clk_CFG);
            rx_valid = 1'b0;
        end else begin
            foreach (bytes[i]) send_byte(bytes[i]);
        end
        repeat (4) @(negedge clk_CFG);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk_CFG);
        check("rst ram_write_n", ram_write_n, 1);
        check("rst ram_read", ram_read, 0);
        check("rst ram_in", ram_in, 0);
        check("rst ram_w_addr", ram_w_addr, 0);
        check("rst busy", busy, 0);
        check("rst frame_ok", frame_ok, 0);
        check("rst frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_CFG);

        // Non-header bytes in IDLE are ignored
        clr();
        send_byte(8'h55);
        send_byte(8'h00);
        repeat (3) @(negedge clk_CFG);
        check("idle junk writes", wq.size(), 0);
        check("idle junk busy", busy, 0);

        // Good frame with gaps
        clr();
        send_frame(8'h00, CMD_START, 8'h00, 1'b0);
        check("good writes", wq.size(), FL);
        check("good first addr", qat(0), 112);
        check("good addr 1 pos", qat(111), 1);
        check("good last addr", qat(112), 0);
        check("good mem112", mem[112], 8'h70);
        check("good mem0", mem[0], CMD_START);
        check("good ok pulses", ok_cnt, 1);
        check("good err pulses", err_cnt, 0);
        check("good ram_read", ram_read, 1);
        check("good busy", busy, 0);

        // Bad checksum: no address-0 write, ram_read low
        clr();
        send_frame(8'h33, 8'h3C, 8'h01, 1'b0);
        check("bad writes", wq.size(), FL - 1);
        check("bad addr0 writes", addr0_writes(), 0);
        check("bad mem0 kept", mem[0], CMD_START);
        check("bad err pulses", err_cnt, 1);
        check("bad ok pulses", ok_cnt, 0);
        check("bad ram_read", ram_read, 0);

        // Good frame restores ram_read; 0xAA payload at addr 40 is data
        clr();
        send_frame(8'h82, CMD_START, 8'h00, 1'b0);
        check("restore ram_read", ram_read, 1);
        check("restore mem40 hdr", mem[40], 8'hAA);
        check("restore ok pulses", ok_cnt, 1);

        // Timeout: byte arriving in the expiry cycle wins, then a real timeout
        clr();
        send_byte(8'hAA);
        for (int i = 0; i < 50; i++) send_byte(pay(112 - i, 8'h00));
        repeat (T - 1) @(negedge clk_CFG);
        send_byte(pay(62, 8'h00));
        check("tie busy", busy, 1);
        check("tie frame_err", frame_err, 0);
        n = 0;
        while (!frame_err && n < T + 20) begin
            @(negedge clk_CFG);
            n++;
        end
        check("timeout latency", n, T + 1);
        @(negedge clk_CFG);
        check("timeout err pulses", err_cnt, 1);
        check("timeout busy", busy, 0);
        check("timeout writes", wq.size(), 51);
        check("timeout ram_read", ram_read, 0);
        clr();
        send_frame(8'h11, CMD_START, 8'h00, 1'b0);
        check("post-timeout first addr", qat(0), 112);
        check("post-timeout ok", ok_cnt, 1);

        // Reset asserted while byte 60 is being written
        clr();
        send_byte(8'hAA);
        for (int i = 0; i < 59; i++) send_byte(pay(112 - i, 8'h00));
        @(negedge clk_CFG);
        rx_data  = pay(53, 8'h00);
        rx_valid = 1'b1;
        @(posedge clk_CFG);
        #1;
        check("byte60 strobe", ram_write_n, 0);
        rst_n = 1'b0;
        #1;
        check("midrst ram_write_n", ram_write_n, 1);
        check("midrst busy", busy, 0);
        check("midrst ram_w_addr", ram_w_addr, 0);
        check("midrst ram_in", ram_in, 0);
        check("midrst ram_read", ram_read, 0);
        rx_valid = 1'b0;
        clr();
        @(negedge clk_CFG);
        rst_n = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (3) @(negedge clk_CFG);
        check("postrst writes", wq.size(), 0);
        check("postrst pulses", ok_cnt + err_cnt, 0);
        clr();
        send_frame(8'h5A, CMD_START, 8'h00, 1'b0);
        check("postrst frame writes", wq.size(), FL);
        check("postrst frame ok", ok_cnt, 1);

        // Back-to-back bytes for a whole frame
        clr();
        send_frame(8'hC3, 8'h7E, 8'h00, 1'b1);
        check("b2b writes", wq.size(), FL);
        check("b2b first addr", qat(0), 112);
        check("b2b last addr", qat(112), 0);
        check("b2b mem1", mem[1], 8'hC2);
        check("b2b mem0", mem[0], 8'h7E);
        check("b2b ok pulses", ok_cnt, 1);
        check("b2b err pulses", err_cnt, 0);
        check("b2b ram_read", ram_read, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
